idex_ctrl_pipe: RTL and testbench

- ID/EX control pipeline stage, directly downstream of the main decoder.
- Registers the decoded control bundle and the register specifiers into the EX stage.
- Resolves the destination register and detects load-use hazards, inserting one bubble and stalling fetch/decode.
- Handles flush (redirect) and external stall (memory wait) with fixed priority.

---
 rtl/idex_ctrl_pipe_if.sv | 70 +++++++
 rtl/idex_ctrl_pipe.sv | 152 +++++++++++++++
 tb/tb_idex_ctrl_pipe.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idex_ctrl_pipe_if.sv
// ID/EX control bundle: decoder-side inputs, EX-side registered outputs, fetch/decode stall.
// The stall_cnt signal exists only when IDEX_STALL_CNT_EN is defined.
interface idex_ctrl_pipe_if
`ifdef IDEX_STALL_CNT_EN
   #(parameter int unsigned CNT_W = 32)
`endif
   ;
   // id_valid qualifies the decode slot on every edge; there is no ready.
   // The upstream side holds its instruction while stall_fd=1.
   logic       stall_in;
   logic       flush;
   logic       id_valid;
   logic       id_memtoreg;
   logic       id_memwrite;
   logic       id_branch;
   logic       id_alusrc;
   logic       id_regdst;
   logic       id_regwrite;
   logic       id_jump;
   logic       id_link;
   logic [1:0] id_aluop;
   logic [2:0] id_branch_op;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic [4:0] id_rd;
   logic       id_use_rs;
   logic       id_use_rt;

   logic       ex_valid;
   logic       ex_memtoreg;
   logic       ex_memwrite;
   logic       ex_branch;
   logic       ex_alusrc;
   logic       ex_regwrite;
   logic       ex_jump;
   logic       ex_link;
   logic [1:0] ex_aluop;
   logic [2:0] ex_branch_op;
   logic [4:0] ex_rs;
   logic [4:0] ex_rt;
   logic [4:0] ex_writereg;
   logic       stall_fd;
`ifdef IDEX_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt;
`endif

   modport master (
      output stall_in, flush, id_valid, id_memtoreg, id_memwrite, id_branch,
             id_alusrc, id_regdst, id_regwrite, id_jump, id_link, id_aluop,
             id_branch_op, id_rs, id_rt, id_rd, id_use_rs, id_use_rt,
      input  ex_valid, ex_memtoreg, ex_memwrite, ex_branch, ex_alusrc,
             ex_regwrite, ex_jump, ex_link, ex_aluop, ex_branch_op, ex_rs,
             ex_rt, ex_writereg, stall_fd
`ifdef IDEX_STALL_CNT_EN
      , input stall_cnt
`endif
   );

   modport slave (
      input  stall_in, flush, id_valid, id_memtoreg, id_memwrite, id_branch,
             id_alusrc, id_regdst, id_regwrite, id_jump, id_link, id_aluop,
             id_branch_op, id_rs, id_rt, id_rd, id_use_rs, id_use_rt,
      output ex_valid, ex_memtoreg, ex_memwrite, ex_branch, ex_alusrc,
             ex_regwrite, ex_jump, ex_link, ex_aluop, ex_branch_op, ex_rs,
             ex_rt, ex_writereg, stall_fd
`ifdef IDEX_STALL_CNT_EN
      , output stall_cnt
`endif
   );
endinterface

// File: rtl/idex_ctrl_pipe.sv
// ID/EX control stage: registers the decoded bundle, resolves the destination register,
// inserts one bubble on load-use. Optional bubble counter under IDEX_STALL_CNT_EN.
module idex_ctrl_pipe
`ifdef IDEX_STALL_CNT_EN
   #(parameter int unsigned CNT_W    = 32,
     parameter int unsigned LINK_REG = 31)
`else
   #(parameter int unsigned LINK_REG = 31)
`endif
(
   input logic             clk,
   input logic             rst,
   idex_ctrl_pipe_if.slave bus
);

   localparam logic [4:0] LINK_REG_C = 5'(LINK_REG);

   typedef struct packed {
      logic       valid;
      logic       memtoreg;
      logic       memwrite;
      logic       branch;
      logic       alusrc;
      logic       regwrite;
      logic       jump;
      logic       link;
      logic [1:0] aluop;
      logic [2:0] branch_op;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] wr;
   } ex_bundle_t;

   typedef enum logic [1:0] {
      ACT_HOLD    = 2'd0,
      ACT_FLUSH   = 2'd1,
      ACT_BUBBLE  = 2'd2,
      ACT_CAPTURE = 2'd3
   } act_e;

   ex_bundle_t ex_q, ex_d, cap_d;
   act_e       act;
   logic [4:0] id_dest;
   logic       load_pending;
   logic       rs_dep;
   logic       rt_dep;
   logic       hazard;

   // Only a valid, register-writing load to a non-zero register can stall its consumer.
   assign load_pending = ex_q.valid & ex_q.memtoreg & ex_q.regwrite & (ex_q.wr != 5'd0);
   assign rs_dep       = bus.id_use_rs & (bus.id_rs == ex_q.wr);
   assign rt_dep       = bus.id_use_rt & (bus.id_rt == ex_q.wr);
   assign hazard       = load_pending & bus.id_valid & (rs_dep | rt_dep);

   // Flush kills the ID instruction, so there is nothing left to hold in fetch/decode.
   assign bus.stall_fd = bus.stall_in | (hazard & ~bus.flush);

   always_comb begin
      act = ACT_CAPTURE;
      if (bus.stall_in) begin
         act = ACT_HOLD;
      end else if (bus.flush) begin
         act = ACT_FLUSH;
      end else if (hazard) begin
         act = ACT_BUBBLE;
      end
   end

   always_comb begin
      id_dest = bus.id_rt;
      if (bus.id_link) begin
         id_dest = LINK_REG_C;
      end else if (bus.id_regdst) begin
         id_dest = bus.id_rd;
      end
   end

   always_comb begin
      cap_d       = '0;
      cap_d.valid = bus.id_valid;
      cap_d.rs    = bus.id_rs;
      cap_d.rt    = bus.id_rt;
      cap_d.wr    = id_dest;
      if (bus.id_valid) begin
         cap_d.memtoreg  = bus.id_memtoreg;
         cap_d.memwrite  = bus.id_memwrite;
         cap_d.branch    = bus.id_branch;
         cap_d.alusrc    = bus.id_alusrc;
         cap_d.regwrite  = bus.id_regwrite & (id_dest != 5'd0);
         cap_d.jump      = bus.id_jump;
         cap_d.link      = bus.id_link;
         cap_d.aluop     = bus.id_aluop;
         cap_d.branch_op = bus.id_branch_op;
      end
   end

   always_comb begin
      ex_d = ex_q;
      case (act)
         ACT_HOLD:    ex_d = ex_q;
         ACT_FLUSH:   ex_d = '0;
         ACT_BUBBLE:  ex_d = '0;
         ACT_CAPTURE: ex_d = cap_d;
         default:     ex_d = ex_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   assign bus.ex_valid     = ex_q.valid;
   assign bus.ex_memtoreg  = ex_q.memtoreg;
   assign bus.ex_memwrite  = ex_q.memwrite;
   assign bus.ex_branch    = ex_q.branch;
   assign bus.ex_alusrc    = ex_q.alusrc;
   assign bus.ex_regwrite  = ex_q.regwrite;
   assign bus.ex_jump      = ex_q.jump;
   assign bus.ex_link      = ex_q.link;
   assign bus.ex_aluop     = ex_q.aluop;
   assign bus.ex_branch_op = ex_q.branch_op;
   assign bus.ex_rs        = ex_q.rs;
   assign bus.ex_rt        = ex_q.rt;
   assign bus.ex_writereg  = ex_q.wr;

`ifdef IDEX_STALL_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counts hazard bubbles only; saturates instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if ((act == ACT_BUBBLE) && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bus.stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_idex_ctrl_pipe.sv
// Bench for idex_ctrl_pipe: hand-computed vector table, corner sequences with async reset,
// then randomized traffic against a spec-level model. Define IDEX_STALL_CNT_EN to check the counter.
module tb_idex_ctrl_pipe;

   typedef struct packed {
      logic       stall_in;
      logic       flush;
      logic       valid;
      logic       memtoreg;
      logic       memwrite;
      logic       branch;
      logic       alusrc;
      logic       regdst;
      logic       regwrite;
      logic       jump;
      logic       link;
      logic       use_rs;
      logic       use_rt;
      logic [1:0] aluop;
      logic [2:0] bop;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
   } in_t;

   typedef struct packed {
      logic       valid;
      logic       memtoreg;
      logic       memwrite;
      logic       branch;
      logic       alusrc;
      logic       regwrite;
      logic       jump;
      logic       link;
      logic [1:0] aluop;
      logic [2:0] bop;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] wr;
   } ex_t;

   typedef struct {
      in_t  in;
      logic fd;
      ex_t  ex;
      logic spec;
      int   cnt;
   } vec_t;

   localparam logic [27:0] CTRL_MASK = 28'hFFF8000;
   localparam int NUM_TBL  = 19;
   localparam int NUM_RAND = 1500;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   ex_t         m_ex;
   logic        m_spec;
   int unsigned m_cnt;
   logic [27:0] exp_q[$];
   vec_t        tbl[NUM_TBL];

   idex_ctrl_pipe_if bus();

   idex_ctrl_pipe dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / watchdog ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- stimulus helpers ----------------
   function automatic in_t i_nop();
      in_t x = '0;
      return x;
   endfunction

   function automatic in_t i_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      in_t x = '0;
      x.valid = 1'b1; x.regdst = 1'b1; x.regwrite = 1'b1; x.aluop = 2'b10;
      x.use_rs = 1'b1; x.use_rt = 1'b1;
      x.rs = rs; x.rt = rt; x.rd = rd;
      return x;
   endfunction

   function automatic in_t i_lw(input logic [4:0] rs, input logic [4:0] rt);
      in_t x = '0;
      x.valid = 1'b1; x.memtoreg = 1'b1; x.alusrc = 1'b1; x.regwrite = 1'b1;
      x.use_rs = 1'b1; x.rs = rs; x.rt = rt;
      return x;
   endfunction

   function automatic in_t i_addi(input logic [4:0] rs, input logic [4:0] rt);
      in_t x = '0;
      x.valid = 1'b1; x.alusrc = 1'b1; x.regwrite = 1'b1;
      x.use_rs = 1'b1; x.rs = rs; x.rt = rt;
      return x;
   endfunction

   function automatic in_t i_bgezal(input logic [4:0] rs);
      in_t x = '0;
      x.valid = 1'b1; x.branch = 1'b1; x.link = 1'b1; x.regwrite = 1'b1;
      x.bop = 3'b101; x.use_rs = 1'b1; x.rs = rs; x.rt = 5'd17;
      return x;
   endfunction

   function automatic in_t with_stall(input in_t x);
      in_t y = x;
      y.stall_in = 1'b1;
      return y;
   endfunction

   function automatic in_t with_flush(input in_t x);
      in_t y = x;
      y.flush = 1'b1;
      return y;
   endfunction

   function automatic ex_t e_mk(input logic v, input logic m2r, input logic mw, input logic br,
                                input logic as, input logic rw, input logic j, input logic lk,
                                input logic [1:0] op, input logic [2:0] bop,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr);
      ex_t e;
      e = '{v, m2r, mw, br, as, rw, j, lk, op, bop, rs, rt, wr};
      return e;
   endfunction

   function automatic in_t rand_in();
      in_t x = '0;
      x.stall_in = ($urandom_range(0, 5) == 0);
      x.flush    = ($urandom_range(0, 7) == 0);
      x.valid    = ($urandom_range(0, 7) != 0);
      x.memtoreg = ($urandom_range(0, 2) == 0);
      x.memwrite = 1'($urandom_range(0, 1));
      x.branch   = 1'($urandom_range(0, 1));
      x.alusrc   = 1'($urandom_range(0, 1));
      x.regdst   = 1'($urandom_range(0, 1));
      x.regwrite = ($urandom_range(0, 3) != 0);
      x.jump     = 1'($urandom_range(0, 1));
      x.link     = ($urandom_range(0, 5) == 0);
      x.use_rs   = 1'($urandom_range(0, 1));
      x.use_rt   = 1'($urandom_range(0, 1));
      x.aluop    = 2'($urandom_range(0, 3));
      x.bop      = 3'($urandom_range(0, 7));
      x.rs       = 5'($urandom_range(0, 5));
      x.rt       = 5'($urandom_range(0, 5));
      x.rd       = 5'($urandom_range(0, 5));
      return x;
   endfunction

   // ---------------- driver ----------------
   task automatic drive_in(input in_t x);
      bus.stall_in     = x.stall_in;
      bus.flush        = x.flush;
      bus.id_valid     = x.valid;
      bus.id_memtoreg  = x.memtoreg;
      bus.id_memwrite  = x.memwrite;
      bus.id_branch    = x.branch;
      bus.id_alusrc    = x.alusrc;
      bus.id_regdst    = x.regdst;
      bus.id_regwrite  = x.regwrite;
      bus.id_jump      = x.jump;
      bus.id_link      = x.link;
      bus.id_aluop     = x.aluop;
      bus.id_branch_op = x.bop;
      bus.id_rs        = x.rs;
      bus.id_rt        = x.rt;
      bus.id_rd        = x.rd;
      bus.id_use_rs    = x.use_rs;
      bus.id_use_rt    = x.use_rt;
   endtask

   function automatic ex_t dut_ex();
      ex_t g;
      g = '{bus.ex_valid, bus.ex_memtoreg, bus.ex_memwrite, bus.ex_branch, bus.ex_alusrc,
            bus.ex_regwrite, bus.ex_jump, bus.ex_link, bus.ex_aluop, bus.ex_branch_op,
            bus.ex_rs, bus.ex_rt, bus.ex_writereg};
      return g;
   endfunction

   // ---------------- reference model ----------------
   function automatic logic m_hazard(input in_t x);
      logic loaded;
      loaded = m_ex.valid && m_ex.memtoreg && m_ex.regwrite && (m_ex.wr != 5'd0) && x.valid;
      return loaded && ((x.use_rs && x.rs == m_ex.wr) || (x.use_rt && x.rt == m_ex.wr));
   endfunction

   task automatic m_reset();
      m_ex   = '0;
      m_spec = 1'b1;
      m_cnt  = 0;
   endtask

   task automatic m_advance(input in_t x);
      logic [4:0] dest;
      logic       hz;
      hz = m_hazard(x);
      if (x.stall_in) begin
         return;
      end
      if (x.flush || hz) begin
         m_ex   = '0;
         m_spec = 1'b1;
         if (!x.flush && m_cnt != 32'hFFFF_FFFF) m_cnt++;
         return;
      end
      dest     = x.link ? 5'd31 : (x.regdst ? x.rd : x.rt);
      m_ex     = '0;
      m_spec   = x.valid;
      m_ex.valid = x.valid;
      m_ex.rs  = x.rs;
      m_ex.rt  = x.rt;
      m_ex.wr  = dest;
      if (x.valid) begin
         m_ex.memtoreg = x.memtoreg;
         m_ex.memwrite = x.memwrite;
         m_ex.branch   = x.branch;
         m_ex.alusrc   = x.alusrc;
         m_ex.regwrite = x.regwrite && (dest != 5'd0);
         m_ex.jump     = x.jump;
         m_ex.link     = x.link;
         m_ex.aluop    = x.aluop;
         m_ex.bop      = x.bop;
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic chk_cnt(input string nm, input int unsigned exp);
`ifdef IDEX_STALL_CNT_EN
      chk(nm, 32'(bus.stall_cnt), exp);
`else
      if (exp != 0) $display("note: %s expected %0d (counter not built)", nm, exp);
`endif
   endtask

   // One cycle: inputs are applied just after a rising edge, stall_fd checked before the next
   // edge, EX contents checked just after it.
   task automatic step(input in_t x, input bit use_tbl, input vec_t v);
      logic [27:0] exp_ex;
      logic [27:0] mask;
      logic        exp_fd;
      ex_t         got;
      drive_in(x);
      #1;
      exp_fd = x.stall_in | (m_hazard(x) & ~x.flush);
      chk("stall_fd", 32'(bus.stall_fd), 32'(exp_fd));
      if (use_tbl) chk("tbl_stall_fd", 32'(bus.stall_fd), 32'(v.fd));
      m_advance(x);
      exp_q.push_back(m_ex);
      @(posedge clk);
      #1;
      got    = dut_ex();
      exp_ex = exp_q.pop_front();
      mask   = m_spec ? 28'hFFFFFFF : CTRL_MASK;
      chk("ex_bundle", 32'(got & mask), 32'(exp_ex & mask));
      chk_cnt("stall_cnt", m_cnt);
      if (use_tbl) begin
         mask = v.spec ? 28'hFFFFFFF : CTRL_MASK;
         chk("tbl_ex_bundle", 32'(got & mask), 32'(v.ex & mask));
         chk_cnt("tbl_stall_cnt", v.cnt);
      end
   endtask

   task automatic check_reset_state(input string nm);
      chk(nm, 32'(dut_ex()), 32'h0);
      chk({nm, "_stall_fd"}, 32'(bus.stall_fd), 32'(bus.stall_in));
      chk_cnt({nm, "_cnt"}, 0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      vec_t dummy;
      in_t  dep;
      n_vec = 0;
      n_err = 0;
      dummy = '{i_nop(), 1'b0, '0, 1'b1, 0};

      tbl[0]  = '{i_rtype(1, 3, 5),  1'b0, e_mk(1,0,0,0,0,1,0,0,2'b10,3'd0, 1, 3, 5),  1'b1, 0};
      tbl[1]  = '{i_lw(2, 8),        1'b0, e_mk(1,1,0,0,1,1,0,0,2'b00,3'd0, 2, 8, 8),  1'b1, 0};
      tbl[2]  = '{i_rtype(8, 4, 9),  1'b1, e_mk(0,0,0,0,0,0,0,0,2'b00,3'd0, 0, 0, 0),  1'b1, 1};
      tbl[3]  = '{i_rtype(8, 4, 9),  1'b0, e_mk(1,0,0,0,0,1,0,0,2'b10,3'd0, 8, 4, 9),  1'b1, 1};
      tbl[4]  = '{i_lw(1, 7),        1'b0, e_mk(1,1,0,0,1,1,0,0,2'b00,3'd0, 1, 7, 7),  1'b1, 1};
      tbl[5]  = '{with_flush(i_rtype(2, 7, 10)),
                                     1'b0, e_mk(0,0,0,0,0,0,0,0,2'b00,3'd0, 0, 0, 0),  1'b1, 1};
      tbl[6]  = '{i_bgezal(3),       1'b0, e_mk(1,0,0,1,0,1,0,1,2'b00,3'd5, 3, 17, 31), 1'b1, 1};
      tbl[7]  = '{i_addi(1, 0),      1'b0, e_mk(1,0,0,0,1,0,0,0,2'b00,3'd0, 1, 0, 0),  1'b1, 1};
      tbl[8]  = '{i_lw(4, 0),        1'b0, e_mk(1,1,0,0,1,0,0,0,2'b00,3'd0, 4, 0, 0),  1'b1, 1};
      tbl[9]  = '{i_rtype(0, 0, 6),  1'b0, e_mk(1,0,0,0,0,1,0,0,2'b10,3'd0, 0, 0, 6),  1'b1, 1};
      tbl[10] = '{with_stall(i_rtype(11, 12, 13)),
                                     1'b1, e_mk(1,0,0,0,0,1,0,0,2'b10,3'd0, 0, 0, 6),  1'b1, 1};
      tbl[11] = '{with_stall(i_lw(14, 15)),
                                     1'b1, e_mk(1,0,0,0,0,1,0,0,2'b10,3'd0, 0, 0, 6),  1'b1, 1};
      tbl[12] = '{with_stall(i_addi(16, 17)),
                                     1'b1, e_mk(1,0,0,0,0,1,0,0,2'b10,3'd0, 0, 0, 6),  1'b1, 1};
      tbl[13] = '{i_addi(16, 17),    1'b0, e_mk(1,0,0,0,1,1,0,0,2'b00,3'd0, 16, 17, 17), 1'b1, 1};
      tbl[14] = '{i_nop(),           1'b0, e_mk(0,0,0,0,0,0,0,0,2'b00,3'd0, 0, 0, 0),  1'b0, 1};
      tbl[15] = '{i_lw(1, 20),       1'b0, e_mk(1,1,0,0,1,1,0,0,2'b00,3'd0, 1, 20, 20), 1'b1, 1};
      tbl[16] = '{with_stall(i_rtype(20, 2, 3)),
                                     1'b1, e_mk(1,1,0,0,1,1,0,0,2'b00,3'd0, 1, 20, 20), 1'b1, 1};
      tbl[17] = '{i_rtype(20, 2, 3), 1'b1, e_mk(0,0,0,0,0,0,0,0,2'b00,3'd0, 0, 0, 0),  1'b1, 2};
      tbl[18] = '{i_rtype(20, 2, 3), 1'b0, e_mk(1,0,0,0,0,1,0,0,2'b10,3'd0, 20, 2, 3), 1'b1, 2};

      // power-on reset
      rst = 1'b1;
      drive_in(i_nop());
      m_reset();
      #2;
      check_reset_state("por_reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < NUM_TBL; i++) begin
         step(tbl[i].in, 1'b1, tbl[i]);
      end

      // reset in the middle of a load-use stall
      step(i_lw(3, 9), 1'b0, dummy);
      dep = i_addi(9, 10);
      drive_in(dep);
      #1;
      chk("pre_reset_hazard_fd", 32'(bus.stall_fd), 32'h1);
      rst = 1'b1;
      #1;
      m_reset();
      check_reset_state("mid_stall_reset");
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
      step(dep, 1'b0, dummy);

      for (int i = 0; i < NUM_RAND; i++) begin
         step(rand_in(), 1'b0, dummy);
      end

      // reset with arbitrary traffic in flight
      drive_in(i_nop());
      #2;
      rst = 1'b1;
      #1;
      m_reset();
      check_reset_state("late_reset");
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 20; i++) begin
         step(rand_in(), 1'b0, dummy);
      end

      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL exp_q_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
